stack_sequencer: RTL and testbench

Multi-cycle controller that sequences the stack pointer and the 16-bit data memory for every stack-touching instruction: PUSH, POP, CALL, RET, INT and RTI. It sits between the decode/execute stage and the stack pointer register. It drives the stack pointer's 3-bit control select and the memory's address and strobes, and stalls the pipeline until each operation completes. 32-bit PC values occupy two memory words; flags occupy one.

---
 rtl/stack_ctrl_defs.sv | 48 ++++
 rtl/stack_sequencer_if.sv | 17 +
 rtl/stack_pointer.sv | 29 ++
 rtl/stack_sequencer.sv | 164 ++++++++++++++++
 tb/tb_stack_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_ctrl_defs.sv
// Shared encodings for the stack sequencer and the stack pointer register:
// op codes, stack pointer control selects and sequencer FSM states.
package stack_ctrl_defs;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_PUSH = 3'b000;
  localparam logic [OP_W-1:0] OP_POP  = 3'b001;
  localparam logic [OP_W-1:0] OP_CALL = 3'b010;
  localparam logic [OP_W-1:0] OP_RET  = 3'b011;
  localparam logic [OP_W-1:0] OP_INT  = 3'b100;
  localparam logic [OP_W-1:0] OP_RTI  = 3'b101;

  typedef enum logic [CTRL_W-1:0] {
    SP_HOLD = 3'b000,
    SP_INC1 = 3'b001,
    SP_DEC1 = 3'b011
  } sp_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_RTI;
  endfunction

  function automatic logic op_is_write(input logic [OP_W-1:0] op);
    return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

  // Index of the last memory word an op touches (words are 0-based).
  function automatic logic [1:0] op_last_idx(input logic [OP_W-1:0] op);
    case (op)
      OP_CALL, OP_RET: return 2'd1;
      OP_INT, OP_RTI:  return 2'd2;
      default:         return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Word-wide data memory port driven by the stack sequencer.
interface stack_sequencer_if
  import stack_ctrl_defs::*;
#(
  parameter int unsigned SP_W = 32
);
  logic [SP_W-1:0]   mem_addr;
  logic              mem_wr;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wr, output mem_rd, output mem_wdata,
                  input  mem_rdata);
  modport slave  (input  mem_addr, input  mem_wr, input  mem_rd, input  mem_wdata,
                  output mem_rdata);
endinterface

// File: rtl/stack_pointer.sv
// Stack pointer register: steps by the sequencer's control select, loadable for setup.
module stack_pointer
  import stack_ctrl_defs::*;
#(
  parameter int unsigned SP_W = 32
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [CTRL_W-1:0] sp_ctrl,
  input  logic              ld,
  input  logic [SP_W-1:0]   ld_value,
  output logic [SP_W-1:0]   sp_value
);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      sp_value <= '0;
    end else if (ld) begin
      sp_value <= ld_value;
    end else begin
      case (sp_ctrl)
        SP_INC1: sp_value <= sp_value + SP_W'(1);
        SP_DEC1: sp_value <= sp_value - SP_W'(1);
        default: sp_value <= sp_value;
      endcase
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle stack sequencer: steps the stack pointer and memory word by word
// for PUSH/POP/CALL/RET/INT/RTI and stalls the pipeline until each op completes.
module stack_sequencer
  import stack_ctrl_defs::*;
#(
  parameter int unsigned SP_W = 32
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               op_valid,
  input  logic [OP_W-1:0]    op_code,
  input  logic [WORD_W-1:0]  push_data,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [FLAG_W-1:0]  flags_in,
  input  logic [SP_W-1:0]    sp_value,
  stack_sequencer_if.master  mem,
  output logic [CTRL_W-1:0]  sp_ctrl,
  output logic               busy,
  output logic               stall_req,
  output logic               done,
  output logic [WORD_W-1:0]  pop_data,
  output logic [PC_W-1:0]    pc_out,
  output logic               pc_load,
  output logic [FLAG_W-1:0]  flags_out,
  output logic               flags_load
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [OP_W-1:0]   op_q;
  logic [PC_W-1:0]   pc_q;
  logic [FLAG_W-1:0] flags_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] pop_q;
  logic [PC_W-1:0]   pc_out_q;
  logic [FLAG_W-1:0] flags_out_q;

  logic              accept_c;
  sp_ctrl_e          ctrl_c;
  logic              wr_c, rd_c, done_c, pc_load_c, flags_load_c;
  logic [SP_W-1:0]   addr_c;
  logic [WORD_W-1:0] wdata_c;
  logic              store_c;
  logic [1:0]        rd_word_c, pc_word_c;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    accept_c     = 1'b0;
    ctrl_c       = SP_HOLD;
    wr_c         = 1'b0;
    rd_c         = 1'b0;
    addr_c       = sp_value;
    wdata_c      = '0;
    done_c       = 1'b0;
    pc_load_c    = 1'b0;
    flags_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && op_legal(op_code)) begin
          accept_c = 1'b1;
          idx_d    = 2'd0;
          state_d  = op_is_write(op_code) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wr_c   = 1'b1;
        ctrl_c = SP_DEC1;
        case (idx_q)
          2'd0:    wdata_c = (op_q == OP_PUSH) ? data_q : pc_q[PC_W-1:WORD_W];
          2'd1:    wdata_c = pc_q[WORD_W-1:0];
          default: wdata_c = WORD_W'(flags_q);
        endcase
        if (idx_q == op_last_idx(op_q)) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_READ: begin
        rd_c   = 1'b1;
        ctrl_c = SP_INC1;
        addr_c = sp_value + SP_W'(1);
        if (idx_q == op_last_idx(op_q)) begin
          state_d = ST_CAPTURE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_CAPTURE: begin
        done_c       = 1'b1;
        pc_load_c    = (op_q == OP_RET) || (op_q == OP_RTI);
        flags_load_c = (op_q == OP_RTI);
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data lags its strobe by a cycle, so each store targets the previous word.
  assign store_c   = ((state_q == ST_READ) && (idx_q != 2'd0)) || (state_q == ST_CAPTURE);
  assign rd_word_c = (state_q == ST_CAPTURE) ? idx_q : idx_q - 2'd1;
  assign pc_word_c = rd_word_c - 2'(op_q == OP_RTI);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      op_q        <= '0;
      pc_q        <= '0;
      flags_q     <= '0;
      data_q      <= '0;
      pop_q       <= '0;
      pc_out_q    <= '0;
      flags_out_q <= '0;
    end else begin
      if (accept_c) begin
        op_q    <= op_code;
        pc_q    <= pc_in;
        flags_q <= flags_in;
        data_q  <= push_data;
      end
      if (store_c) begin
        if (op_q == OP_POP) begin
          pop_q <= mem.mem_rdata;
        end else if ((op_q == OP_RTI) && (rd_word_c == 2'd0)) begin
          flags_out_q <= mem.mem_rdata[FLAG_W-1:0];
        end else if (pc_word_c == 2'd0) begin
          pc_out_q[WORD_W-1:0] <= mem.mem_rdata;
        end else begin
          pc_out_q[PC_W-1:WORD_W] <= mem.mem_rdata;
        end
      end
    end
  end

  assign mem.mem_addr  = addr_c;
  assign mem.mem_wr    = wr_c;
  assign mem.mem_rd    = rd_c;
  assign mem.mem_wdata = wdata_c;

  assign sp_ctrl    = ctrl_c;
  assign busy       = (state_q != ST_IDLE);
  assign stall_req  = busy | accept_c;
  assign done       = done_c;
  assign pc_load    = pc_load_c;
  assign flags_load = flags_load_c;
  assign flags_out  = flags_out_q;

  // The final word arrives during CAPTURE; forward it so results are valid with done.
  assign pop_data = ((state_q == ST_CAPTURE) && (op_q == OP_POP)) ? mem.mem_rdata : pop_q;
  assign pc_out   = ((state_q == ST_CAPTURE) && (op_q != OP_POP)) ?
                    {mem.mem_rdata, pc_out_q[WORD_W-1:0]} : pc_out_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer with the stack pointer and a synchronous word RAM.
module tb_stack_sequencer;
  import stack_ctrl_defs::*;

  localparam int unsigned SP_W   = 32;
  localparam int unsigned NSCHED = 1024;

  logic        clk = 1'b0;
  logic        Rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [15:0] push_data;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic [31:0] sp_value;
  logic [2:0]  sp_ctrl;
  logic        busy, stall_req, done, pc_load, flags_load;
  logic [15:0] pop_data;
  logic [31:0] pc_out;
  logic [3:0]  flags_out;
  logic        sp_ld;
  logic [31:0] sp_ld_value;

  stack_sequencer_if #(.SP_W(SP_W)) mbus ();

  stack_sequencer #(.SP_W(SP_W)) dut (
    .clk(clk), .Rst(Rst), .op_valid(op_valid), .op_code(op_code),
    .push_data(push_data), .pc_in(pc_in), .flags_in(flags_in), .sp_value(sp_value),
    .mem(mbus), .sp_ctrl(sp_ctrl), .busy(busy), .stall_req(stall_req), .done(done),
    .pop_data(pop_data), .pc_out(pc_out), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load)
  );

  stack_pointer #(.SP_W(SP_W)) u_sp (
    .clk(clk), .Rst(Rst), .sp_ctrl(sp_ctrl), .ld(sp_ld), .ld_value(sp_ld_value),
    .sp_value(sp_value)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:4095];
  logic        ram_fill;

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 16'(i) ^ 16'h5A5A;
      mbus.mem_rdata <= 16'h0;
    end else begin
      if (mbus.mem_wr) ram[mbus.mem_addr[11:0]] <= mbus.mem_wdata;
      if (mbus.mem_rd) mbus.mem_rdata <= ram[mbus.mem_addr[11:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  ctrl;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        stall;
    logic        done;
    logic        pcl;
    logic        fll;
    logic        chk_pop;
    logic [15:0] pop;
    logic        chk_pc;
    logic [31:0] pc;
    logic        chk_fl;
    logic [3:0]  fl;
    logic [31:0] sp;
  } exp_t;

  exp_t        sched [0:NSCHED-1];
  logic [15:0] mem_m [0:4095];
  logic [31:0] sp_m;
  logic        chk_en;
  exp_t        cmp_e;

  function automatic exp_t idle_exp(input logic [31:0] s, input logic st);
    exp_t e;
    e.v = 1'b1; e.ctrl = 3'b000; e.wr = 1'b0; e.rd = 1'b0; e.addr = s; e.wdata = 16'h0;
    e.busy = 1'b0; e.stall = st; e.done = 1'b0; e.pcl = 1'b0; e.fll = 1'b0;
    e.chk_pop = 1'b0; e.pop = 16'h0; e.chk_pc = 1'b0; e.pc = 32'h0;
    e.chk_fl = 1'b0; e.fl = 4'h0; e.sp = s;
    return e;
  endfunction

  // Expected per-cycle behaviour of one op accepted in the current cycle.
  task automatic plan(input logic [2:0] op, input logic [31:0] pcv, input logic [3:0] flv,
                      input logic [15:0] pd);
    int          n;
    int          k;
    logic        is_wr;
    logic [31:0] s, a;
    logic [15:0] w [3];
    exp_t        e;
    n = cyc;
    s = sp_m;
    e = idle_exp(s, 1'b1);
    if (n < NSCHED) sched[n] = e;
    w[0] = pd; w[1] = 16'h0; w[2] = 16'h0;
    case (op)
      3'b000: begin k = 1; is_wr = 1'b1; end
      3'b010: begin k = 2; is_wr = 1'b1; w[0] = pcv[31:16]; w[1] = pcv[15:0]; end
      3'b100: begin k = 3; is_wr = 1'b1; w[0] = pcv[31:16]; w[1] = pcv[15:0]; w[2] = {12'h0, flv}; end
      3'b001: begin k = 1; is_wr = 1'b0; end
      3'b011: begin k = 2; is_wr = 1'b0; end
      default: begin k = 3; is_wr = 1'b0; end
    endcase
    e.busy = 1'b1;
    if (is_wr) begin
      for (int i = 0; i < k; i++) begin
        a = s - 32'(i);
        e.ctrl = 3'b011; e.wr = 1'b1; e.addr = a; e.wdata = w[i]; e.sp = a;
        e.done = (i == k - 1);
        if (n + 1 + i < NSCHED) sched[n + 1 + i] = e;
        mem_m[a[11:0]] = w[i];
      end
      sp_m = s - 32'(k);
    end else begin
      for (int i = 0; i < k; i++) begin
        a = s + 32'(i) + 32'd1;
        w[i] = mem_m[a[11:0]];
        e.ctrl = 3'b001; e.rd = 1'b1; e.addr = a; e.sp = s + 32'(i);
        if (n + 1 + i < NSCHED) sched[n + 1 + i] = e;
      end
      e = idle_exp(s + 32'(k), 1'b1);
      e.busy = 1'b1; e.done = 1'b1;
      e.pcl = (op != 3'b001);
      e.fll = (op == 3'b101);
      if (op == 3'b001) begin
        e.chk_pop = 1'b1; e.pop = w[0];
      end else if (op == 3'b011) begin
        e.chk_pc = 1'b1; e.pc = {w[1], w[0]};
      end else begin
        e.chk_pc = 1'b1; e.pc = {w[2], w[1]};
        e.chk_fl = 1'b1; e.fl = w[0][3:0];
      end
      if (n + 1 + k < NSCHED) sched[n + 1 + k] = e;
      sp_m = s + 32'(k);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc < NSCHED && sched[cyc].v) cmp_e = sched[cyc];
      else cmp_e = idle_exp(sp_m, op_valid && (op_code < 3'd6));
      chk("sp_ctrl", 32'(sp_ctrl), 32'(cmp_e.ctrl));
      chk("mem_wr", 32'(mbus.mem_wr), 32'(cmp_e.wr));
      chk("mem_rd", 32'(mbus.mem_rd), 32'(cmp_e.rd));
      chk("mem_addr", mbus.mem_addr, cmp_e.addr);
      if (cmp_e.wr) chk("mem_wdata", 32'(mbus.mem_wdata), 32'(cmp_e.wdata));
      chk("busy", 32'(busy), 32'(cmp_e.busy));
      chk("stall_req", 32'(stall_req), 32'(cmp_e.stall));
      chk("done", 32'(done), 32'(cmp_e.done));
      chk("pc_load", 32'(pc_load), 32'(cmp_e.pcl));
      chk("flags_load", 32'(flags_load), 32'(cmp_e.fll));
      chk("sp_value", sp_value, cmp_e.sp);
      if (cmp_e.chk_pop) chk("pop_data", 32'(pop_data), 32'(cmp_e.pop));
      if (cmp_e.chk_pc) chk("pc_out", pc_out, cmp_e.pc);
      if (cmp_e.chk_fl) chk("flags_out", 32'(flags_out), 32'(cmp_e.fl));
    end
  end

  task automatic set_sp(input logic [31:0] v);
    sp_ld = 1'b1;
    sp_ld_value = v;
    @(posedge clk); #1;
    sp_ld = 1'b0;
    sp_m = v;
  endtask

  // Issue one op, hold the request until done, and pin the done latency.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] pcv,
                        input logic [3:0] flv, input logic [15:0] pd, input int exp_lat);
    int n0;
    int lat;
    lat = 99;
    op_code = op; pc_in = pcv; flags_in = flv; push_data = pd; op_valid = 1'b1;
    plan(op, pcv, flv, pd);
    n0 = cyc;
    for (int i = 0; i < 8 && lat == 99; i++) begin
      @(negedge clk);
      if (done) lat = cyc - n0;
    end
    chk({nm, " done latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; ram_fill = 1'b1; chk_en = 1'b0; sp_ld = 1'b0; sp_ld_value = 32'h0;
    op_valid = 1'b0; op_code = 3'b000; push_data = 16'h0; pc_in = 32'h0; flags_in = 4'h0;
    sp_m = 32'h0;
    for (int i = 0; i < 4096; i++) mem_m[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < int'(NSCHED); i++) sched[i] = idle_exp(32'h0, 1'b0);
    for (int i = 0; i < int'(NSCHED); i++) sched[i].v = 1'b0;
    #1 Rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 ram_fill = 1'b0;
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst sp_ctrl", 32'(sp_ctrl), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst pop_data", 32'(pop_data), 32'h0);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst flags_out", 32'(flags_out), 32'h0);
    chk("rst loads", 32'({pc_load, flags_load}), 32'h0);
    Rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-INT, after the first of its three writes.
    set_sp(32'h0000_07FF);
    op_code = 3'b100; pc_in = 32'h1234_5678; flags_in = 4'h3; op_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    Rst = 1'b1; op_valid = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst sp_ctrl", 32'(sp_ctrl), 32'h0);
    chk("midrst mem_wr", 32'(mbus.mem_wr), 32'h0);
    chk("midrst done", 32'(done), 32'h0);
    chk("midrst sp", sp_value, 32'h0);
    chk("midrst ram 7ff", 32'(ram[12'h7FF]), 32'h0000_1234);
    chk("midrst ram 7fe", 32'(ram[12'h7FE]), 32'h0000_5DA4);
    mem_m[12'h7FF] = 16'h1234;
    sp_m = 32'h0;
    @(posedge clk); #1;
    Rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    set_sp(32'h0000_07FF);
    run_op("push after rst", 3'b000, 32'h0, 4'h0, 16'h1111, 1);
    chk("push after rst ram", 32'(ram[12'h7FF]), 32'h0000_1111);
    run_op("pop after rst", 3'b001, 32'h0, 4'h0, 16'h0, 2);
    chk("pop after rst data", 32'(pop_data), 32'h0000_1111);

    run_op("push beef", 3'b000, 32'h0, 4'h0, 16'hBEEF, 1);
    chk("push beef ram", 32'(ram[12'h7FF]), 32'h0000_BEEF);
    chk("push beef sp", sp_value, 32'h0000_07FE);
    run_op("pop beef", 3'b001, 32'h0, 4'h0, 16'h0, 2);
    chk("pop beef data", 32'(pop_data), 32'h0000_BEEF);
    chk("pop beef sp", sp_value, 32'h0000_07FF);

    run_op("call", 3'b010, 32'h0001_2345, 4'h0, 16'h0, 2);
    chk("call ram 7ff", 32'(ram[12'h7FF]), 32'h0000_0001);
    chk("call ram 7fe", 32'(ram[12'h7FE]), 32'h0000_2345);
    chk("call sp", sp_value, 32'h0000_07FD);
    run_op("ret", 3'b011, 32'h0, 4'h0, 16'h0, 3);
    chk("ret pc_out", pc_out, 32'h0001_2345);
    chk("ret sp", sp_value, 32'h0000_07FF);

    run_op("int", 3'b100, 32'hAAAA_5555, 4'hA, 16'h0, 3);
    chk("int ram 7ff", 32'(ram[12'h7FF]), 32'h0000_AAAA);
    chk("int ram 7fe", 32'(ram[12'h7FE]), 32'h0000_5555);
    chk("int ram 7fd", 32'(ram[12'h7FD]), 32'h0000_000A);
    chk("int sp", sp_value, 32'h0000_07FC);
    run_op("rti", 3'b101, 32'h0, 4'h0, 16'h0, 4);
    chk("rti flags_out", 32'(flags_out), 32'h0000_000A);
    chk("rti pc_out", pc_out, 32'hAAAA_5555);
    chk("rti sp", sp_value, 32'h0000_07FF);

    // Request held high: three back-to-back PUSHes, one accept every other cycle.
    op_code = 3'b000; op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_data = 16'((i + 1) * 257);
      plan(3'b000, 32'h0, 4'h0, push_data);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    chk("held ram 7ff", 32'(ram[12'h7FF]), 32'h0000_0101);
    chk("held ram 7fe", 32'(ram[12'h7FE]), 32'h0000_0202);
    chk("held ram 7fd", 32'(ram[12'h7FD]), 32'h0000_0303);
    chk("held sp", sp_value, 32'h0000_07FC);

    op_code = 3'b111; op_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 op_valid = 1'b0;
    chk("illegal sp", sp_value, 32'h0000_07FC);
    chk("illegal ram 7fc", 32'(ram[12'h7FC]), 32'h0000_5DA6);

    set_sp(32'hFFFF_FFFF);
    run_op("wrap pop", 3'b001, 32'h0, 4'h0, 16'h0, 2);
    chk("wrap pop data", 32'(pop_data), 32'h0000_5A5A);
    chk("wrap sp", sp_value, 32'h0000_0000);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
